// File: rtl/mgc_ioport_pkg.sv
// Shared helpers for the mgc I/O port buffer/FIFO family: sizing, parameter
// legality and the handshake-fire primitive.
package mgc_ioport_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return r;
    endfunction

    // A counter of sz_width bits must be able to hold the full depth.
    function automatic bit fifo_params_ok(input int rscid, input int width, input int depth,
                                          input int sz_width, input int afull_lvl);
        return (rscid >= 0) && (width >= 1) && (depth >= 1)
            && (sz_width >= 1) && (sz_width < 31) && ((1 << sz_width) > depth)
            && (afull_lvl >= 1) && (afull_lvl <= depth);
    endfunction

    function automatic logic fire(input logic l, input logic v);
        return l && v;
    endfunction

endpackage

// File: rtl/mgc_fifo_store.sv
// depth x width register array: one synchronous write port, one asynchronous
// read port. Data storage is never reset.
module mgc_fifo_store #(
    parameter int width = 8,
    parameter int depth = 8,
    parameter int aw    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [aw-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [aw-1:0]    raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mgc_out_fifo_wait_lvl.sv
// Wait-handshake output FIFO with arbitrary depth, optional fall-through,
// registered occupancy and almost-full level.
module mgc_out_fifo_wait_lvl
    import mgc_ioport_pkg::*;
#(
    parameter int rscid     = 0,
    parameter int width     = 8,
    parameter int fifo_sz   = 8,
    parameter int sz_width  = 4,
    parameter int fall_thru = 0,
    parameter int afull_lvl = 6
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                en,
    input  logic                ld,
    output logic                vd,
    input  logic [width-1:0]    d,
    output logic                lz,
    input  logic                vz,
    output logic [width-1:0]    z,
    output logic [sz_width-1:0] size,
    output logic                afull
);

    if (!fifo_params_ok(rscid, width, fifo_sz, sz_width, afull_lvl)) begin : g_param_err
        $error("mgc_out_fifo_wait_lvl: illegal parameter combination");
    end

    localparam int AW_RAW = clog2(fifo_sz);
    localparam int AW     = (AW_RAW < 1) ? 1 : AW_RAW;
    localparam bit FT     = (fall_thru != 0);

    localparam logic [sz_width-1:0] DEPTH = sz_width'(fifo_sz);
    localparam logic [sz_width-1:0] AFULL = sz_width'(afull_lvl);
    localparam logic [sz_width-1:0] ONE   = sz_width'(1);
    localparam logic [AW-1:0]       LAST  = AW'(fifo_sz - 1);

    logic [sz_width-1:0] count_q, count_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic                afull_q, afull_d;

    logic             run, empty, bypass, wr, rd;
    logic [width-1:0] rdata;

    // Non-power-of-2 depth: wrap on an explicit compare with the last index.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        run    = en && !srst;
        empty  = (count_q == '0);
        vd     = run && (count_q < DEPTH);
        lz     = run && (!empty || (FT && ld));
        // An empty fall-through FIFO hands d straight to z without storing it.
        bypass = FT && empty && run && fire(ld, vz);
        wr     = fire(ld, vd) && !bypass;
        rd     = fire(lz, vz) && !bypass;

        wr_ptr_d = wr ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (wr && !rd) begin
            count_d = count_q + ONE;
        end else if (rd && !wr) begin
            count_d = count_q - ONE;
        end
        afull_d = (count_d >= AFULL);

        if (!empty) begin
            z = rdata;
        end else if (FT) begin
            z = d;
        end else begin
            z = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            afull_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            afull_q  <= afull_d;
        end
    end

    mgc_fifo_store #(
        .width (width),
        .depth (fifo_sz),
        .aw    (AW)
    ) u_store (
        .clk   (clk),
        .we    (wr),
        .waddr (wr_ptr_q),
        .wdata (d),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign size  = count_q;
    assign afull = afull_q;

endmodule

// File: tb/tb_mgc_out_fifo_wait_lvl.sv
// Bench for mgc_out_fifo_wait_lvl: a registered and a fall-through instance
// share stimulus and are each checked against a queue-based reference.
module tb_mgc_out_fifo_wait_lvl;

    localparam int W  = 8;
    localparam int SZ = 5;
    localparam int SW = 4;
    localparam int AL = 4;

    typedef logic [W-1:0] q_t[$];

    typedef struct {
        logic         rs;
        logic         e;
        logic         l;
        logic [W-1:0] dd;
        logic         v;
        logic         x_vd;
        logic         x_lz;
        logic [W-1:0] x_z;
        logic [SW-1:0] x_sz;
        logic         x_af;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          srst, en, ld, vz;
    logic [W-1:0]  d;
    logic          vd0, lz0, af0, vd1, lz1, af1;
    logic [W-1:0]  z0, z1;
    logic [SW-1:0] sz0, sz1;

    int n_cmp = 0;
    int n_fail = 0;
    q_t q0, q1;
    vec_t tbl[14];

    mgc_out_fifo_wait_lvl #(
        .rscid(1), .width(W), .fifo_sz(SZ), .sz_width(SW), .fall_thru(0), .afull_lvl(AL)
    ) dut0 (
        .clk(clk), .srst(srst), .en(en), .ld(ld), .vd(vd0), .d(d),
        .lz(lz0), .vz(vz), .z(z0), .size(sz0), .afull(af0)
    );

    mgc_out_fifo_wait_lvl #(
        .rscid(2), .width(W), .fifo_sz(SZ), .sz_width(SW), .fall_thru(1), .afull_lvl(AL)
    ) dut1 (
        .clk(clk), .srst(srst), .en(en), .ld(ld), .vd(vd1), .d(d),
        .lz(lz1), .vz(vz), .z(z1), .size(sz1), .afull(af1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected outputs follow from the queue contents and the current inputs.
    task automatic mchk(input int k, input logic a_vd, input logic a_lz, input logic [W-1:0] a_z,
                        input logic [SW-1:0] a_sz, input logic a_af);
        q_t q;
        bit ft, run, e_vd, e_lz;
        if (k == 0) q = q0; else q = q1;
        ft   = (k == 1);
        run  = en && !srst;
        e_vd = run && (q.size() < SZ);
        e_lz = run && ((q.size() > 0) || (ft && ld));
        chk($sformatf("m%0d_vd", k), a_vd, e_vd);
        chk($sformatf("m%0d_lz", k), a_lz, e_lz);
        if (e_lz) chk($sformatf("m%0d_z", k), a_z, (q.size() > 0) ? q[0] : d);
        chk($sformatf("m%0d_size", k), a_sz, SW'(q.size()));
        chk($sformatf("m%0d_afull", k), a_af, q.size() >= AL);
    endtask

    task automatic mupd(input int k);
        q_t q;
        bit ft, push, pop;
        if (k == 0) q = q0; else q = q1;
        ft = (k == 1);
        if (srst) begin
            q.delete();
        end else if (en && !(ft && q.size() == 0 && ld && vz)) begin
            push = ld && (q.size() < SZ);
            pop  = vz && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
        end
        if (k == 0) q0 = q; else q1 = q;
    endtask

    task automatic apply(input logic rs, input logic e, input logic l, input logic [W-1:0] dd,
                         input logic v);
        srst = rs; en = e; ld = l; d = dd; vz = v;
        @(negedge clk);
        mchk(0, vd0, lz0, z0, sz0, af0);
        mchk(1, vd1, lz1, z1, sz1, af1);
    endtask

    task automatic tick();
        @(posedge clk);
        mupd(0);
        mupd(1);
        #1;
    endtask

    function automatic vec_t mk(input logic rs, input logic e, input logic l, input logic [W-1:0] dd,
                                input logic v, input logic x_vd, input logic x_lz,
                                input logic [W-1:0] x_z, input logic [SW-1:0] x_sz, input logic x_af);
        vec_t r;
        r.rs = rs; r.e = e; r.l = l; r.dd = dd; r.v = v;
        r.x_vd = x_vd; r.x_lz = x_lz; r.x_z = x_z; r.x_sz = x_sz; r.x_af = x_af;
        return r;
    endfunction

    initial begin
        srst = 1'b1; en = 1'b1; ld = 1'b0; vz = 1'b0; d = '0;
        @(posedge clk);
        #1;

        // Registered instance: reset, fill to full, full+read, drain.
        tbl[0]  = mk(1'b1, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 8'h11, 4'd1, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b1, 8'h13, 1'b0, 1'b1, 1'b1, 8'h11, 4'd2, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 8'h11, 4'd3, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b1, 8'h15, 1'b0, 1'b1, 1'b1, 8'h11, 4'd4, 1'b1);
        tbl[7]  = mk(1'b0, 1'b1, 1'b1, 8'h16, 1'b1, 1'b0, 1'b1, 8'h11, 4'd5, 1'b1);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h12, 4'd4, 1'b1);
        tbl[9]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 4'd4, 1'b1);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h13, 4'd3, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h14, 4'd2, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h15, 4'd1, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].rs, tbl[i].e, tbl[i].l, tbl[i].dd, tbl[i].v);
            chk($sformatf("t%0d_vd", i), vd0, tbl[i].x_vd);
            chk($sformatf("t%0d_lz", i), lz0, tbl[i].x_lz);
            if (tbl[i].x_lz) chk($sformatf("t%0d_z", i), z0, tbl[i].x_z);
            chk($sformatf("t%0d_size", i), sz0, tbl[i].x_sz);
            chk($sformatf("t%0d_afull", i), af0, tbl[i].x_af);
            tick();
        end

        // Steady simultaneous read/write at size 3, pointers wrap repeatedly.
        apply(1'b1, 1'b1, 1'b0, 8'h00, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 1'b1, 8'(8'h20 + i), 1'b0); tick();
        end
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'b1, 1'b1, 8'(8'h30 + i), 1'b1);
            chk("wrap_size0", sz0, 4'd3);
            chk("wrap_size1", sz1, 4'd3);
            tick();
        end

        // Fall-through bypass, then fall-through store.
        apply(1'b1, 1'b1, 1'b0, 8'h00, 1'b0); tick();
        apply(1'b0, 1'b1, 1'b1, 8'hA5, 1'b1);
        chk("ft_bypass_z", z1, 8'hA5);
        chk("ft_bypass_lz", lz1, 1'b1);
        tick();
        apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("ft_bypass_size", sz1, 4'd0);
        tick();
        apply(1'b1, 1'b1, 1'b0, 8'h00, 1'b0); tick();
        apply(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
        chk("ft_store_lz", lz1, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            chk("ft_store_size", sz1, 4'd1);
            chk("ft_store_z", z1, 8'hA5);
            tick();
        end

        // Enable low freezes everything; mid-run reset discards stored words.
        apply(1'b1, 1'b1, 1'b0, 8'h00, 1'b0); tick();
        apply(1'b0, 1'b1, 1'b1, 8'h61, 1'b0); tick();
        apply(1'b0, 1'b1, 1'b1, 8'h62, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b1, 8'h63, 1'b1);
            chk("en_vd", vd0, 1'b0);
            chk("en_lz", lz0, 1'b0);
            chk("en_size", sz0, 4'd2);
            tick();
        end
        apply(1'b1, 1'b1, 1'b1, 8'h64, 1'b1); tick();
        apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("rst_size", sz0, 4'd0);
        chk("rst_lz", lz0, 1'b0);
        tick();
        apply(1'b0, 1'b1, 1'b1, 8'h77, 1'b0); tick();
        apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_newdata", z0, 8'h77);
        tick();

        // Random traffic: producer-heavy first half, consumer-heavy second half.
        for (int i = 0; i < 400; i++) begin
            logic rs, e, l, v;
            rs = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 7) != 0);
            l  = (i < 200) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            v  = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            apply(rs, e, l, 8'($urandom), v);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
